hdmi_audio_packetizer: RTL and testbench
========================================

# hdmi_audio_packetizer

- Buffers PCM audio frames from a free-running audio source.
- Formats them into HDMI audio sample packets: header plus four subpackets with IEC 60958 V/U/C/P bits and block-start flags.
- Hands each packet to the data-island scheduler on request.
- Generalises the fixed 2-channel/16-bit audio path of the HDMI data encoder: channel count, sample width and FIFO depth are parametrised, and the block adds layout-1 multichannel packets, a handshake and overflow/underflow reporting.

## Interface
Parameters:
- CHANNELS, 2: audio channels per frame; legal values 2, 4, 6, 8. The value 2 selects layout 0; greater than 2 selects layout 1.
- SAMPLE_W, 16: sample width, 16..24; samples are left-justified into 24-bit fields.
- FIFO_DEPTH, 8: frame FIFO depth, a power of 2 and at least 4.
- CHANNEL_STATUS, 192'hc202004004: IEC 60958 channel-status block; bit i is sent with frame i of each block.

Ports:
- i_pixclk  in  1  pixel clock; the only clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_sample_valid  in  1  frame offered.
- o_sample_ready  out  1  FIFO not full.
- i_sample  in  CHANNELS*SAMPLE_W  channel k at [k*SAMPLE_W +: SAMPLE_W].
- i_pkt_req  in  1  single-cycle packet request from the scheduler.
- o_pkt_valid  out  1  packet available; held until acknowledged.
- i_pkt_ack  in  1  scheduler consumed the packet.
- o_pkt_header  out  24  {HB2,HB1,HB0}.
- o_pkt_sub  out  224  subpacket k at [56k +: 56].
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  frames buffered.
- o_overflow  out  1  sticky flag.
- o_underflow  out  1  sticky flag.
- i_clear_flags  in  1  synchronous clear of both sticky flags.

## Operation
FIFO:
- A frame is pushed when i_sample_valid && o_sample_ready.
- o_sample_ready = !full, and is forced to 0 while i_reset is high.
- o_overflow is set when i_sample_valid && !o_sample_ready; the frame is dropped and the contents are unchanged.
- Push and pop in the same cycle leave the level unchanged.

State machine IDLE -> GATHER -> VALID -> IDLE:
- IDLE: i_pkt_req loads the header and subpacket registers with zero, enters GATHER, and sets slot = 0.
- GATHER: runs exactly MAXS cycles (MAXS = 4 in layout 0, 1 in layout 1). Each cycle pops one frame if the FIFO is non-empty and places it in the next free slot; an empty cycle places nothing.
- GATHER -> VALID: o_pkt_valid = 1.
- VALID -> IDLE on i_pkt_ack.
- i_pkt_req is ignored outside IDLE; i_pkt_ack is ignored outside VALID.
- If a completed GATHER popped zero frames, o_underflow is set and the packet is still presented with no samples present.

Sample formatting, per channel:
- field = sample << (24 - SAMPLE_W).
- C = CHANNEL_STATUS[frame_idx]; V = U = 0.
- P = ^sample ^ C.
- Subpacket bits: [23:0] even channel, [47:24] odd channel, 48 V_e, 49 U_e, 50 C_e, 51 P_e, 52 V_o, 53 U_o, 54 C_o, 55 P_o.

frame_idx:
- 8-bit, increments on each pop, wraps 191 -> 0.
- A frame popped with frame_idx == 0 is a block start.

Header:
- HB0 = 0x02.
- HB1 = {3'b0, layout, present[3:0]}.
- HB2 = {4'b0, B[3:0]}.

Layout 0:
- Frame n of the packet goes to subpacket n, holding L and R.
- present[n] = 1 for each filled slot.
- B[n] = 1 if that frame is a block start.
- Unfilled subpackets are 0.

Layout 1:
- One frame per packet; subpacket k holds channels 2k and 2k+1.
- present = (1 << CHANNELS/2) - 1.
- Only B[0] is used, set on a block start.
- Subpackets beyond CHANNELS/2 are 0.

## Timing
- Request issued in cycle t: o_pkt_valid is first high in cycle t+MAXS+1, and the header and subpackets are stable for as long as valid stays high.
- o_pkt_valid falls the cycle after i_pkt_ack is sampled high.
- o_fifo_level, o_sample_ready and o_overflow are registered and update one cycle after a push or pop.
- i_clear_flags has priority over a same-cycle set.
- Reset values:
  - o_pkt_valid 0.
  - Header and subpackets 0.
  - o_fifo_level 0.
  - Both flags 0.
  - frame_idx 0.
  - State IDLE.
  - o_sample_ready 0 during reset, 1 after reset.
- Reset mid-GATHER or mid-VALID discards the partial packet and the FIFO contents.

## Test plan
1. **Layout 0, full packet.** Push 4 frames L=0x1234, R=0x8001, then pulse req at t. Required: valid at t+5, header 24'h010F02, sub0 = 56'h08800100123400, sub2 = 56'hC4800100123400 (C=1 at idx 2).
2. **Partial packet.** Push 2 frames, then req. Required: HB1 = 0x03, sub2 = sub3 = 0, level goes 2 -> 0. The frame held while valid is high without ack is not re-popped.
3. **Underflow.** With the FIFO empty, req. Required: valid with header 24'h000002, o_underflow = 1. Then i_clear_flags -> o_underflow = 0.
4. **Block wrap.** Stream 196 frames across 49 full packets. Required: only packets 1 and 49 have HB2 = 0x01; all others have HB2 = 0x00.
5. **Overflow.** FIFO_DEPTH = 8; push 9 frames with no requests. Required: ready = 0 at level 8, o_overflow = 1, and the 8 popped frames match the first 8 pushed.
6. **Layout 1, reset mid-operation.** CHANNELS = 8, SAMPLE_W = 24; push 1 frame, then req. Required: header 24'h011F02. Then push a frame, req, and assert i_reset during GATHER. Required: valid 0 and level 0 immediately.

Source files
------------

// File: rtl/hdmi_audio_packetizer.sv
// Buffers PCM frames in a small FIFO and assembles HDMI audio sample packets
// (layout 0 for stereo, layout 1 for multichannel) for the data-island scheduler.
//
// state  | meaning
// IDLE   | waiting for a packet request from the scheduler
// GATHER | popping frames into subpacket slots for MAXS cycles
// VALID  | packet presented, waiting for acknowledge
module hdmi_audio_packetizer #(
   parameter int           CHANNELS       = 2,
   parameter int           SAMPLE_W       = 16,
   parameter int           FIFO_DEPTH     = 8,
   parameter logic [191:0] CHANNEL_STATUS = 192'hc202004004
) (
   input  logic                            i_pixclk,
   input  logic                            i_reset,
   input  logic                            i_sample_valid,
   output logic                            o_sample_ready,
   input  logic [CHANNELS*SAMPLE_W-1:0]    i_sample,
   input  logic                            i_pkt_req,
   output logic                            o_pkt_valid,
   input  logic                            i_pkt_ack,
   output logic [23:0]                     o_pkt_header,
   output logic [223:0]                    o_pkt_sub,
   output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
   output logic                            o_overflow,
   output logic                            o_underflow,
   input  logic                            i_clear_flags
);

   localparam int         AW         = $clog2(FIFO_DEPTH);
   localparam int         FW         = CHANNELS * SAMPLE_W;
   localparam int         PAIRS      = CHANNELS / 2;
   localparam logic       LAYOUT     = (CHANNELS > 2);
   localparam int         MAXS       = LAYOUT ? 1 : 4;
   localparam logic [3:0] PRESENT_L1 = 4'((1 << PAIRS) - 1);
   localparam logic [AW:0] DEPTH_L   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, GATHER, VALID} state_t;

   state_t          state_q, state_d;
   logic [1:0]      cyc_q, cyc_d;
   logic [2:0]      slot_q, slot_d;
   logic [7:0]      idx_q, idx_d;
   logic [23:0]     hdr_q, hdr_d;
   logic [223:0]    sub_q, sub_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q, level_d;
   logic            ready_q, ready_d;
   logic            ovf_q, ovf_d;
   logic            udf_q, udf_d;
   logic            udf_set;
   logic [FW-1:0]   mem_q [FIFO_DEPTH];

   logic            push, pop, empty, c_bit, blk_start;
   logic [FW-1:0]   rd_data;

   function automatic logic [23:0] justify(input logic [SAMPLE_W-1:0] s);
      return 24'(s) << (24 - SAMPLE_W);
   endfunction

   // One subpacket: two 24-bit fields then V/U/C/P for even, then odd channel.
   function automatic logic [55:0] fmt_sub(input logic [SAMPLE_W-1:0] se,
                                           input logic [SAMPLE_W-1:0] so,
                                           input logic c);
      logic pe, po;
      pe = (^se) ^ c;
      po = (^so) ^ c;
      return {po, c, 1'b0, 1'b0, pe, c, 1'b0, 1'b0, justify(so), justify(se)};
   endfunction

   assign o_sample_ready = ready_q & ~i_reset;
   assign push           = i_sample_valid & o_sample_ready;
   assign empty          = (level_q == '0);
   assign pop            = (state_q == GATHER) & ~empty;
   assign rd_data        = mem_q[rd_ptr_q];
   assign c_bit          = CHANNEL_STATUS[idx_q];
   assign blk_start      = (idx_q == 8'd0);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      ready_d = (level_d != DEPTH_L);
      idx_d   = idx_q;
      if (pop) idx_d = (idx_q == 8'd191) ? 8'd0 : idx_q + 8'd1;
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      slot_d  = slot_q;
      hdr_d   = hdr_q;
      sub_d   = sub_q;
      udf_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_pkt_req) begin
               state_d = GATHER;
               cyc_d   = 2'(MAXS - 1);
               slot_d  = 3'd0;
               hdr_d   = {8'h00, 3'b000, LAYOUT, 4'h0, 8'h02};
               sub_d   = '0;
            end
         end
         GATHER: begin
            if (pop) begin
               slot_d = slot_q + 3'd1;
               if (!LAYOUT) begin
                  for (int n = 0; n < 4; n++) begin
                     if (slot_q[1:0] == 2'(n)) begin
                        sub_d[56*n +: 56] = fmt_sub(rd_data[0 +: SAMPLE_W],
                                                    rd_data[SAMPLE_W +: SAMPLE_W], c_bit);
                        hdr_d[8+n]  = 1'b1;
                        hdr_d[16+n] = blk_start;
                     end
                  end
               end else begin
                  for (int k = 0; k < PAIRS; k++) begin
                     sub_d[56*k +: 56] = fmt_sub(rd_data[2*k*SAMPLE_W +: SAMPLE_W],
                                                 rd_data[(2*k+1)*SAMPLE_W +: SAMPLE_W], c_bit);
                  end
                  hdr_d[11:8] = PRESENT_L1;
                  hdr_d[16]   = blk_start;
               end
            end
            // The packet is presented even when nothing was gathered.
            if (cyc_q == 2'd0) begin
               state_d = VALID;
               udf_set = (slot_d == 3'd0);
            end else begin
               cyc_d = cyc_q - 2'd1;
            end
         end
         VALID: begin
            if (i_pkt_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ovf_d = i_clear_flags ? 1'b0 : (ovf_q | (i_sample_valid & ~o_sample_ready));
      udf_d = i_clear_flags ? 1'b0 : (udf_q | udf_set);
   end

   always_ff @(posedge i_pixclk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= IDLE;
         cyc_q    <= '0;
         slot_q   <= '0;
         idx_q    <= '0;
         hdr_q    <= '0;
         sub_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ready_q  <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         slot_q   <= slot_d;
         idx_q    <= idx_d;
         hdr_q    <= hdr_d;
         sub_q    <= sub_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ready_q  <= ready_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage needs no reset: pointers and level define what is valid.
   always_ff @(posedge i_pixclk) begin
      if (push) mem_q[wr_ptr_q] <= i_sample;
   end

   assign o_pkt_valid  = (state_q == VALID);
   assign o_pkt_header = hdr_q;
   assign o_pkt_sub    = sub_q;
   assign o_fifo_level = level_q;
   assign o_overflow   = ovf_q;
   assign o_underflow  = udf_q;

endmodule

// File: tb/tb_hdmi_audio_packetizer.sv
// Directed bench for hdmi_audio_packetizer: stereo instance plus an 8-channel/24-bit instance,
// expected packets queued at request time and compared when valid rises.
module tb_hdmi_audio_packetizer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, sv, req, ack, clr;
   logic [31:0]  smp;
   logic         rdy, pv, ovf, udf;
   logic [23:0]  hdr;
   logic [223:0] sub;
   logic [3:0]   lvl;

   logic         rst8, sv8, req8, ack8, clr8;
   logic [191:0] smp8;
   logic         rdy8, pv8, ovf8, udf8;
   logic [23:0]  hdr8;
   logic [223:0] sub8;
   logic [3:0]   lvl8;

   hdmi_audio_packetizer u_dut (
      .i_pixclk(clk), .i_reset(rst), .i_sample_valid(sv), .o_sample_ready(rdy),
      .i_sample(smp), .i_pkt_req(req), .o_pkt_valid(pv), .i_pkt_ack(ack),
      .o_pkt_header(hdr), .o_pkt_sub(sub), .o_fifo_level(lvl),
      .o_overflow(ovf), .o_underflow(udf), .i_clear_flags(clr));

   hdmi_audio_packetizer #(.CHANNELS(8), .SAMPLE_W(24)) u_dut8 (
      .i_pixclk(clk), .i_reset(rst8), .i_sample_valid(sv8), .o_sample_ready(rdy8),
      .i_sample(smp8), .i_pkt_req(req8), .o_pkt_valid(pv8), .i_pkt_ack(ack8),
      .o_pkt_header(hdr8), .o_pkt_sub(sub8), .o_fifo_level(lvl8),
      .o_overflow(ovf8), .o_underflow(udf8), .i_clear_flags(clr8));

   typedef struct {
      logic [23:0]  hdr;
      logic [223:0] sub;
   } pkt_t;

   pkt_t         exp_q[$];
   logic [31:0]  fq[$];
   logic [191:0] fq8[$];
   logic [7:0]   m_idx, m_idx8;
   logic [191:0] cs_v;
   int           n_assert = 0;
   int           n_fail   = 0;

   function automatic logic [55:0] mfmt(input logic [23:0] fe, input logic [23:0] fo, input logic c);
      logic [7:0] b;
      b = {(^fo) ^ c, c, 2'b00, (^fe) ^ c, c, 2'b00};
      return {b, fo, fe};
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [31:0] f);
      sv = 1'b1;
      smp = f;
      if (fq.size() < 8) fq.push_back(f);
      tick();
      sv = 1'b0;
   endtask

   task automatic push8(input logic [191:0] f);
      sv8 = 1'b1;
      smp8 = f;
      if (fq8.size() < 8) fq8.push_back(f);
      tick();
      sv8 = 1'b0;
   endtask

   task automatic req0();
      pkt_t e;
      logic [31:0] f;
      int n;
      e.hdr = 24'h000002;
      e.sub = '0;
      for (int s = 0; s < 4; s++) begin
         if (fq.size() > 0) begin
            f = fq.pop_front();
            e.sub[56*s +: 56] = mfmt({f[15:0], 8'h00}, {f[31:16], 8'h00}, cs_v[m_idx]);
            e.hdr[8+s]  = 1'b1;
            e.hdr[16+s] = (m_idx == 8'd0);
            m_idx = (m_idx == 8'd191) ? 8'd0 : m_idx + 8'd1;
         end
      end
      exp_q.push_back(e);
      req = 1'b1;
      tick();
      req = 1'b0;
      n = 1;
      while (!pv && n < 20) begin
         tick();
         n++;
      end
      chk("l0_latency", 256'(n), 256'(5));
      e = exp_q.pop_front();
      if (pv) begin
         chk("l0_header", 256'(hdr), 256'(e.hdr));
         chk("l0_sub", 256'(sub), 256'(e.sub));
      end
   endtask

   task automatic ack0();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("l0_valid_fall", 256'(pv), 256'(0));
   endtask

   task automatic req8_t();
      pkt_t e;
      logic [191:0] f;
      int n;
      e.hdr = 24'h001002;
      e.sub = '0;
      if (fq8.size() > 0) begin
         f = fq8.pop_front();
         for (int k = 0; k < 4; k++)
            e.sub[56*k +: 56] = mfmt(f[48*k +: 24], f[48*k+24 +: 24], cs_v[m_idx8]);
         e.hdr[15:8] = 8'h1F;
         e.hdr[16]   = (m_idx8 == 8'd0);
         m_idx8 = (m_idx8 == 8'd191) ? 8'd0 : m_idx8 + 8'd1;
      end
      exp_q.push_back(e);
      req8 = 1'b1;
      tick();
      req8 = 1'b0;
      n = 1;
      while (!pv8 && n < 20) begin
         tick();
         n++;
      end
      chk("l1_latency", 256'(n), 256'(2));
      e = exp_q.pop_front();
      if (pv8) begin
         chk("l1_header", 256'(hdr8), 256'(e.hdr));
         chk("l1_sub", 256'(sub8), 256'(e.sub));
      end
   endtask

   initial begin
      logic [191:0] f8;
      cs_v = 192'hc202004004;
      m_idx = 8'd0;
      m_idx8 = 8'd0;
      rst = 1'b1; sv = 1'b0; req = 1'b0; ack = 1'b0; clr = 1'b0; smp = '0;
      rst8 = 1'b1; sv8 = 1'b0; req8 = 1'b0; ack8 = 1'b0; clr8 = 1'b0; smp8 = '0;
      tick();
      tick();
      chk("rst_ready", 256'(rdy), 256'(0));
      chk("rst_valid", 256'(pv), 256'(0));
      chk("rst_header", 256'(hdr), 256'(0));
      chk("rst_sub", 256'(sub), 256'(0));
      chk("rst_level", 256'(lvl), 256'(0));
      chk("rst_flags", 256'({ovf, udf}), 256'(0));
      rst = 1'b0;
      rst8 = 1'b0;
      tick();
      chk("post_rst_ready", 256'(rdy), 256'(1));

      // Full layout-0 packet with the documented constant values.
      for (int i = 0; i < 4; i++) push0(32'h8001_1234);
      chk("t1_level", 256'(lvl), 256'(4));
      req0();
      chk("t1_header_const", 256'(hdr), 256'(24'h010F02));
      chk("t1_sub0_const", 256'(sub[55:0]), 256'(56'h08800100123400));
      chk("t1_sub2_const", 256'(sub[167:112]), 256'(56'hC4800100123400));
      chk("t1_level_after", 256'(lvl), 256'(0));
      ack0();

      // Partial packet; a frame arriving while valid is held must stay buffered.
      push0(32'h7FFF_00FF);
      push0(32'h0001_ABCD);
      chk("t2_level", 256'(lvl), 256'(2));
      req0();
      chk("t2_hb1", 256'(hdr[15:8]), 256'(8'h03));
      chk("t2_sub23_zero", 256'(sub[223:112]), 256'(0));
      chk("t2_level_after", 256'(lvl), 256'(0));
      push0(32'h5555_AAAA);
      tick();
      tick();
      chk("t2_hold_level", 256'(lvl), 256'(1));
      chk("t2_hold_valid", 256'(pv), 256'(1));
      chk("t2_hold_hb1", 256'(hdr[15:8]), 256'(8'h03));
      ack0();
      req0();
      chk("t2_drain_hb1", 256'(hdr[15:8]), 256'(8'h01));
      ack0();

      // Underflow on an empty FIFO, then clear.
      chk("t3_udf_before", 256'(udf), 256'(0));
      req0();
      chk("t3_header_const", 256'(hdr), 256'(24'h000002));
      chk("t3_udf_set", 256'(udf), 256'(1));
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t3_udf_clear", 256'(udf), 256'(0));
      ack0();

      // Overflow: ninth frame dropped, first eight delivered in order.
      for (int i = 0; i < 9; i++) begin
         push0(32'hA000_0000 + 32'(i * 32'h0001_0003));
         if (i == 7) begin
            chk("t5_level_full", 256'(lvl), 256'(8));
            chk("t5_ready_full", 256'(rdy), 256'(0));
            chk("t5_ovf_before", 256'(ovf), 256'(0));
         end
      end
      chk("t5_ovf_set", 256'(ovf), 256'(1));
      chk("t5_level_kept", 256'(lvl), 256'(8));
      req0();
      ack0();
      req0();
      ack0();
      chk("t5_level_drained", 256'(lvl), 256'(0));
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t5_ovf_clear", 256'(ovf), 256'(0));

      // Block wrap over 196 frames from a fresh reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      fq.delete();
      exp_q.delete();
      m_idx = 8'd0;
      tick();
      for (int p = 0; p < 49; p++) begin
         for (int i = 0; i < 4; i++) push0($urandom);
         req0();
         chk($sformatf("t4_hb2_p%0d", p + 1), 256'(hdr[23:16]),
             256'((p == 0 || p == 48) ? 8'h01 : 8'h00));
         ack0();
      end

      // Layout 1 (8 channels, 24-bit).
      for (int i = 0; i < 6; i++) f8[32*i +: 32] = $urandom;
      push8(f8);
      req8_t();
      chk("t6_header_const", 256'(hdr8), 256'(24'h011F02));
      ack8 = 1'b1;
      tick();
      ack8 = 1'b0;
      chk("t6_valid_fall", 256'(pv8), 256'(0));
      for (int i = 0; i < 6; i++) f8[32*i +: 32] = $urandom;
      push8(f8);
      req8 = 1'b1;
      tick();
      req8 = 1'b0;
      chk("t6_level_in_gather", 256'(lvl8), 256'(1));
      rst8 = 1'b1;
      #1;
      chk("t6_rst_valid", 256'(pv8), 256'(0));
      chk("t6_rst_level", 256'(lvl8), 256'(0));
      chk("t6_rst_ready", 256'(rdy8), 256'(0));
      tick();
      rst8 = 1'b0;
      fq8.delete();
      m_idx8 = 8'd0;
      tick();
      tick();
      chk("t6_after_valid", 256'(pv8), 256'(0));
      chk("t6_after_header", 256'(hdr8), 256'(0));
      chk("t6_after_ready", 256'(rdy8), 256'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
